// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state encoding and helpers for the hold arbiter
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot_from_id(input logic [ID_W-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational cyclic search of four requests starting at ptr
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  logic [ID_W-1:0] idx;

  // Scan from the farthest offset back to ptr so the nearest requester wins.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ptr + ID_W'(i);
      if (req[idx]) begin
        valid = 1'b1;
        id    = idx;
      end
    end
  end

endmodule

// File: rtl/rr_hold_arbiter4.sv
// rtl/rr_hold_arbiter4.sv - four-way round-robin arbiter with bounded grant hold
module rr_hold_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0,
  input  logic            req1,
  input  logic            req2,
  input  logic            req3,
  output logic            gnt0,
  output logic            gnt1,
  output logic            gnt2,
  output logic            gnt3,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);

  state_t              state, state_n;
  logic [NUM_REQ-1:0]  gnt_q, gnt_n;
  logic [ID_W-1:0]     id_q, id_n;
  logic [ID_W-1:0]     ptr_q, ptr_n;
  logic [CNT_W-1:0]    hold_q, hold_n;
  logic                timeout_q, timeout_n;

  logic [NUM_REQ-1:0]  req;
  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;

  assign req = {req3, req2, req1, req0};

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .id    (pick_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      gnt_q     <= gnt_n;
      id_q      <= id_n;
      ptr_q     <= ptr_n;
      hold_q    <= hold_n;
      timeout_q <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_q;
    id_n      = id_q;
    ptr_n     = ptr_q;
    hold_n    = hold_q;
    timeout_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = GRANT;
          gnt_n   = onehot_from_id(pick_id);
          id_n    = pick_id;
          hold_n  = CNT_W'(1);
          ptr_n   = pick_id + ID_W'(1);
        end
      end

      GRANT: begin
        if (!req[id_q]) begin
          if (pick_valid) begin
            gnt_n  = onehot_from_id(pick_id);
            id_n   = pick_id;
            hold_n = CNT_W'(1);
            ptr_n  = pick_id + ID_W'(1);
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            hold_n  = '0;
          end
        end else if (hold_q == HOLD_LIMIT) begin
          // ptr already sits past the owner, so the owner is searched last;
          // it still requests, so the pick cannot come back empty.
          timeout_n = 1'b1;
          gnt_n     = onehot_from_id(pick_id);
          id_n      = pick_id;
          hold_n    = CNT_W'(1);
          ptr_n     = pick_id + ID_W'(1);
        end else begin
          hold_n = hold_q + CNT_W'(1);
        end
      end

      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        hold_n  = '0;
      end
    endcase
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign gnt2    = gnt_q[2];
  assign gnt3    = gnt_q[3];
  assign gnt_id  = id_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_hold_arbiter4.sv
// tb/tb_rr_hold_arbiter4.sv - directed self-checking bench for rr_hold_arbiter4
module tb_rr_hold_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       gnt0, gnt1, gnt2, gnt3;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rr_hold_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req0    (req[0]),
    .req1    (req[1]),
    .req2    (req[2]),
    .req3    (req[3]),
    .gnt0    (gnt0),
    .gnt1    (gnt1),
    .gnt2    (gnt2),
    .gnt3    (gnt3),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic to);
    chk({tag, ".gnt"}, 32'({gnt3, gnt2, gnt1, gnt0}), 32'(g));
    chk({tag, ".id"}, 32'(gnt_id), 32'(id));
    chk({tag, ".busy"}, 32'(busy), 32'(g != 4'b0));
    chk({tag, ".timeout"}, 32'(timeout), 32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b1111;

    // 1: reset holds everything low even with all requests up
    tick();
    expect_out("t1.rst0", 4'b0000, 2'd0, 1'b0);
    tick();
    expect_out("t1.rst1", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("t1.first", 4'b0001, 2'd0, 1'b0);

    // 2: short request gives exactly three grant cycles
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_out($sformatf("t2.hold%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    req = 4'b0000;
    tick();
    expect_out("t2.release", 4'b0000, 2'd0, 1'b0);

    // 3: all requesting rotates every eight cycles with a timeout pulse
    do_reset();
    req = 4'b1111;
    for (int o = 0; o < 5; o++) begin
      for (int c = 0; c < 8; c++) begin
        tick();
        expect_out($sformatf("t3.o%0d.c%0d", o, c), 4'(1 << (o % 4)), 2'(o % 4),
                   (c == 0) && (o > 0));
      end
    end
    req = 4'b0000;
    tick();
    expect_out("t3.idle", 4'b0000, 2'd0, 1'b0);

    // 4: lone requester is regranted without a gap, pulsing timeout
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 20; c++) begin
      tick();
      expect_out($sformatf("t4.c%0d", c), 4'b0100, 2'd2, (c == 8) || (c == 16));
    end

    // 5: late request does not preempt, then takes over on release
    do_reset();
    req = 4'b0010;
    tick();
    expect_out("t5.g1", 4'b0010, 2'd1, 1'b0);
    req = 4'b1010;
    tick();
    expect_out("t5.nopreempt", 4'b0010, 2'd1, 1'b0);
    req = 4'b1000;
    tick();
    expect_out("t5.handoff", 4'b1000, 2'd3, 1'b0);
    req = 4'b0000;
    tick();
    expect_out("t5.idle_keeps_id", 4'b0000, 2'd3, 1'b0);

    // 6: reset mid-grant clears outputs and pointer
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 4; c++) begin
      tick();
      expect_out($sformatf("t6.g2.c%0d", c), 4'b0100, 2'd2, 1'b0);
    end
    rst = 1'b1;
    req = 4'b0101;
    tick();
    expect_out("t6.rst", 4'b0000, 2'd0, 1'b0);
    rst = 1'b0;
    tick();
    expect_out("t6.after", 4'b0001, 2'd0, 1'b0);

    // 7: release on the same edge as the hold limit is a normal release
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      expect_out($sformatf("t7.c%0d", c), 4'b0001, 2'd0, 1'b0);
    end
    req = 4'b0010;
    tick();
    expect_out("t7.normal", 4'b0010, 2'd1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
